// File: rtl/out_pack_writer.sv
// Byte-lane write-back stage: packs an 8-bit result stream into 32-bit memory words,
// one single-cycle byte write per accepted result, then optionally flushes and signals done.
module out_pack_writer #(
  parameter int ADDR_LIMIT    = 128,
  parameter bit FLUSH_ON_DONE = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] base_addr,
  input  logic [9:0] byte_count,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       write,
  output logic [7:0] address,
  output logic [1:0] offset,
  output logic [7:0] data,
  output logic       writeOut,
  output logic       busy,
  output logic       done,
  output logic       wrapped
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  localparam logic [7:0] LAST_WORD = 8'(ADDR_LIMIT - 1);

  state_t     state_q, state_d;
  logic [9:0] count_q, count_d;
  logic [9:0] index_q, index_d;
  logic [7:0] word_q, word_d;
  logic       word_passed_q, word_passed_d;
  logic       in_ready_q, in_ready_d;
  logic       write_q, write_d;
  logic [7:0] address_q, address_d;
  logic [1:0] offset_q, offset_d;
  logic [7:0] data_q, data_d;
  logic       write_out_q, write_out_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       wrapped_q, wrapped_d;

  logic [7:0] base_mod;
  logic       xfer;

  assign base_mod = 8'({24'd0, base_addr} % 32'(ADDR_LIMIT));
  assign xfer     = in_valid && in_ready_q;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    index_d       = index_q;
    word_d        = word_q;
    word_passed_d = word_passed_q;
    address_d     = address_q;
    offset_d      = offset_q;
    data_d        = data_q;
    wrapped_d     = wrapped_q;
    write_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_d        = base_mod;
          count_d       = byte_count;
          index_d       = 10'd0;
          word_passed_d = 1'b0;
          wrapped_d     = 1'b0;
          state_d       = (byte_count == 10'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          write_d   = 1'b1;
          data_d    = in_data;
          offset_d  = index_q[1:0];
          address_d = word_q;
          // word_passed_q is set once word_q has rolled over, so only a byte that
          // actually lands on a wrapped address marks the run as wrapped
          wrapped_d = wrapped_q | word_passed_q;
          index_d   = 10'(index_q + 10'd1);
          if (index_q[1:0] == 2'd3) begin
            if (word_q == LAST_WORD) begin
              word_d        = 8'd0;
              word_passed_d = 1'b1;
            end else begin
              word_d = 8'(word_q + 8'd1);
            end
          end
          if (index_d == count_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = FLUSH_ON_DONE ? S_FLUSH : S_DONE;
      S_FLUSH: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it
    in_ready_d  = (state_d == S_RUN);
    write_out_d = (state_d == S_FLUSH);
    done_d      = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      count_q       <= 10'd0;
      index_q       <= 10'd0;
      word_q        <= 8'd0;
      word_passed_q <= 1'b0;
      in_ready_q    <= 1'b0;
      write_q       <= 1'b0;
      address_q     <= 8'd0;
      offset_q      <= 2'd0;
      data_q        <= 8'd0;
      write_out_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      wrapped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      index_q       <= index_d;
      word_q        <= word_d;
      word_passed_q <= word_passed_d;
      in_ready_q    <= in_ready_d;
      write_q       <= write_d;
      address_q     <= address_d;
      offset_q      <= offset_d;
      data_q        <= data_d;
      write_out_q   <= write_out_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      wrapped_q     <= wrapped_d;
    end
  end

  assign in_ready = in_ready_q;
  assign write    = write_q;
  assign address  = address_q;
  assign offset   = offset_q;
  assign data     = data_q;
  assign writeOut = write_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign wrapped  = wrapped_q;

endmodule

// File: tb/tb_out_pack_writer.sv
// Randomized bench for out_pack_writer: one instance with flush, one without, sharing stimulus.
module tb_out_pack_writer;

  localparam int LIMIT = 128;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] base_addr;
  logic [9:0] byte_count;
  logic       in_valid;
  logic [7:0] in_data;

  logic       in_ready_f, write_f, writeOut_f, busy_f, done_f, wrapped_f;
  logic [7:0] address_f, data_f;
  logic [1:0] offset_f;
  logic       in_ready_n, write_n, writeOut_n, busy_n, done_n, wrapped_n;
  logic [7:0] address_n, data_n;
  logic [1:0] offset_n;

  out_pack_writer #(.ADDR_LIMIT(LIMIT), .FLUSH_ON_DONE(1'b1)) dut_f (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .byte_count(byte_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_f), .write(write_f), .address(address_f), .offset(offset_f),
    .data(data_f), .writeOut(writeOut_f), .busy(busy_f), .done(done_f), .wrapped(wrapped_f)
  );

  out_pack_writer #(.ADDR_LIMIT(LIMIT), .FLUSH_ON_DONE(1'b0)) dut_n (
    .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
    .byte_count(byte_count), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready_n), .write(write_n), .address(address_n), .offset(offset_n),
    .data(data_n), .writeOut(writeOut_n), .busy(busy_n), .done(done_n), .wrapped(wrapped_n)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [1:0] off;
    logic [7:0] data;
  } wr_ev_t;

  wr_ev_t wr_f[$];
  wr_ev_t wr_n[$];
  int     wo_f[$], wo_n[$], dn_f[$], dn_n[$];
  int     overlap = 0;

  // Memory-side view: every cycle with write high is one captured byte
  always @(negedge clock) begin
    wr_ev_t e;
    if (write_f) begin
      e.cyc = cyc; e.addr = address_f; e.off = offset_f; e.data = data_f;
      wr_f.push_back(e);
    end
    if (write_n) begin
      e.cyc = cyc; e.addr = address_n; e.off = offset_n; e.data = data_n;
      wr_n.push_back(e);
    end
    if (writeOut_f) wo_f.push_back(cyc);
    if (writeOut_n) wo_n.push_back(cyc);
    if (done_f) dn_f.push_back(cyc);
    if (done_n) dn_n.push_back(cyc);
    if ((write_f && writeOut_f) || (write_n && writeOut_n)) overlap++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // mode: 0 = in_valid held high, 1 = toggling 1,0,1,..., 2 = random
  // rst_after < 0: complete run; otherwise reset after that many bytes were written
  task automatic run(input logic [7:0] base, input int cnt, input int mode,
                     input int rst_after, input bit mid_start, input bit fixed_data);
    logic [7:0] bytes[$];
    int xcyc[$];
    int bm, target, sent, guard, t_start, t_last, nw, exp_wo, exp_wrap;
    int wf0, wn0, wof0, won0, dnf0, dnn0;
    bit v, xfer, tgl;
    wr_ev_t e;

    bm = int'(base) % LIMIT;
    for (int i = 0; i < cnt; i++) bytes.push_back(fixed_data ? 8'(8'hA0 + i) : 8'($urandom));
    target = (rst_after >= 0) ? rst_after : cnt;
    wf0 = wr_f.size(); wn0 = wr_n.size(); wof0 = wo_f.size(); won0 = wo_n.size();
    dnf0 = dn_f.size(); dnn0 = dn_n.size();

    @(posedge clock); #1;
    start = 1'b1; base_addr = base; byte_count = 10'(cnt);
    @(posedge clock); #1;
    t_start = cyc;
    t_last = t_start;
    start = 1'b0; base_addr = 8'($urandom); byte_count = 10'($urandom);
    check("wrapped_cleared", wrapped_f, 0);
    check("busy_after_start", busy_f, 1);

    sent = 0; guard = 0; tgl = 1'b1;
    while (sent < target && guard < 4 * cnt + 20) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tgl : 1'($urandom_range(0, 1));
      tgl = ~tgl;
      in_valid = v;
      in_data = bytes[sent];
      if (mid_start && sent == 2) begin
        start = 1'b1; base_addr = 8'h55; byte_count = 10'd3;
      end
      @(negedge clock);
      xfer = v && in_ready_f;
      @(posedge clock); #1;
      start = 1'b0;
      if (xfer) begin
        sent++;
        xcyc.push_back(cyc);
        t_last = cyc;
      end
      guard++;
    end
    in_valid = 1'b0;
    check("bytes_accepted", sent, target);

    if (rst_after >= 0) begin
      @(posedge clock); #1;
      reset = 1'b1;
      #1;
      check("midrst_outputs", {in_ready_f, write_f, address_f, offset_f, data_f,
                               writeOut_f, busy_f, done_f, wrapped_f}, 0);
      check("midrst_busy_n", busy_n, 0);
      @(negedge clock);
      reset = 1'b0;
      repeat (4) @(posedge clock);
      #1;
    end else begin
      repeat (4) @(posedge clock);
      #1;
    end

    nw = wr_f.size() - wf0;
    check("write_count_f", nw, target);
    check("write_count_n", wr_n.size() - wn0, target);
    for (int i = 0; i < target && i < nw; i++) begin
      e = wr_f[wf0 + i];
      check("wr_addr", e.addr, (bm + i / 4) % LIMIT);
      check("wr_offset", e.off, i % 4);
      check("wr_data", e.data, bytes[i]);
      check("wr_cycle", e.cyc, xcyc[i]);
    end
    for (int i = 0; i < target && i < wr_n.size() - wn0; i++) begin
      e = wr_n[wn0 + i];
      check("wr_n_fields", {e.addr, 6'd0, e.off, e.data},
            {8'((bm + i / 4) % LIMIT), 6'd0, 2'(i % 4), bytes[i]});
    end

    exp_wo = (rst_after < 0 && cnt > 0) ? 1 : 0;
    check("writeOut_count_f", wo_f.size() - wof0, exp_wo);
    if (exp_wo == 1 && wo_f.size() > wof0) check("writeOut_cycle", wo_f[wof0], t_last + 1);
    check("writeOut_count_n", wo_n.size() - won0, 0);

    if (rst_after < 0) begin
      check("done_count_f", dn_f.size() - dnf0, 1);
      check("done_count_n", dn_n.size() - dnn0, 1);
      if (dn_f.size() > dnf0) check("done_cycle_f", dn_f[dnf0], (cnt > 0) ? t_last + 2 : t_start);
      if (dn_n.size() > dnn0) check("done_cycle_n", dn_n[dnn0], (cnt > 0) ? t_last + 1 : t_start);
    end else begin
      check("done_count_rst", dn_f.size() - dnf0, 0);
    end

    exp_wrap = (rst_after < 0 && cnt > 0 && bm + (cnt - 1) / 4 >= LIMIT) ? 1 : 0;
    check("wrapped_f", wrapped_f, exp_wrap);
    check("wrapped_n", wrapped_n, exp_wrap);
    check("idle_at_end", {busy_f, busy_n, in_ready_f, in_ready_n}, 0);
    $display("run base=0x%02h cnt=%0d mode=%0d rst_after=%0d writes=%0d", base, cnt, mode, rst_after, nw);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = 8'd0; byte_count = 10'd0;
    in_valid = 1'b0; in_data = 8'd0;
    #1;
    check("reset_outputs_f", {in_ready_f, write_f, address_f, offset_f, data_f,
                              writeOut_f, busy_f, done_f, wrapped_f}, 0);
    check("reset_outputs_n", {in_ready_n, write_n, address_n, offset_n, data_n,
                              writeOut_n, busy_n, done_n, wrapped_n}, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    run(8'h10, 8, 0, -1, 1'b0, 1'b1);   // full rate
    run(8'h20, 5, 1, -1, 1'b0, 1'b0);   // stalled producer
    run(8'd127, 6, 0, -1, 1'b0, 1'b0);  // address wrap
    run(8'h30, 0, 0, -1, 1'b0, 1'b0);   // zero count, clears wrapped
    run(8'h40, 8, 0, -1, 1'b1, 1'b0);   // start during RUN ignored
    run(8'h50, 8, 0, 3, 1'b0, 1'b0);    // reset mid-run
    run(8'h50, 4, 0, -1, 1'b0, 1'b0);   // fresh run after reset
    run(8'd200, 9, 2, -1, 1'b0, 1'b0);  // base beyond limit
    run(8'd126, 20, 2, -1, 1'b0, 1'b0);
    for (int r = 0; r < 8; r++) begin
      run(8'($urandom), $urandom_range(1, 24), $urandom_range(0, 2), -1, 1'b0, 1'b0);
    end

    check("write_writeOut_overlap", overlap, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
